// File: rtl/ifetch_unit_pkg.sv
// Shared word width, reset PC, instruction size and fetch FSM state type for the
// ifetch_unit slice.
package ifetch_unit_pkg;

    localparam int unsigned           WORD_WIDTH  = 32;
    localparam logic [WORD_WIDTH-1:0] IF_RESET_PC = 32'h0000_0000;
    localparam int unsigned           INST_BYTES  = 4;

    typedef enum logic [1:0] {
        IF_ST_IDLE  = 2'd0,
        IF_ST_REQ   = 2'd1,
        IF_ST_FLUSH = 2'd2
    } if_state_e;

endpackage

// File: rtl/ifetch_unit_queue.sv
// Prefetch FIFO of {inst, pc} pairs; flush has priority over push, and the head
// reads as zero whenever the queue is empty.
module ifetch_queue
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned W     = WORD_WIDTH,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           push_inst,
    input  logic [W-1:0]           push_pc,
    output logic                   head_valid,
    output logic [W-1:0]           head_inst,
    output logic [W-1:0]           head_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  inst_mem [DEPTH];
    logic [W-1:0]  pc_mem   [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && (cnt_q != '0) && !flush;
        do_push = push && !flush && ((cnt_q != CW'(DEPTH)) || do_pop);
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_pop)  rd_d = rd_q + 1'b1;
            if (do_push) wr_d = wr_q + 1'b1;
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            inst_mem[wr_q] <= push_inst;
            pc_mem[wr_q]   <= push_pc;
        end
    end

    assign head_valid = (cnt_q != '0);
    assign head_inst  = head_valid ? inst_mem[rd_q] : '0;
    assign head_pc    = head_valid ? pc_mem[rd_q]   : '0;
    assign count      = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: fetch PC, single-outstanding imem req/ack FSM, redirect target latch.
// IFETCH_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag (fetch_err).
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned  W        = WORD_WIDTH,
    parameter int unsigned  DEPTH    = 2,
    parameter logic [W-1:0] RESET_PC = IF_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect_en,
    input  logic [W-1:0] redirect_pc,
    input  logic         stall,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [W-1:0] imem_rdata,
    output logic         inst_valid,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    output logic         fetch_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    if_state_e     state_q, state_d;
    logic [W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [W-1:0]  targ_q, targ_d;
    logic [W-1:0]  redir_tgt;
    logic          err_q, err_d;
    logic          misalign;
    logic          push, pop;
    logic [CW-1:0] q_count, cnt_pop;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign redir_tgt = redirect_pc;
    assign misalign  = redirect_en && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_tgt = redirect_pc & ~W'(INST_BYTES - 1);
    assign misalign  = 1'b0;
`endif

    assign pop = inst_valid && !stall;

    // Space checks use the post-pop occupancy so a full queue being drained can issue.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        targ_d     = targ_q;
        err_d      = err_q | misalign;
        push       = 1'b0;
        cnt_pop    = q_count - CW'(pop);
        unique case (state_q)
            IF_ST_IDLE: begin
                if (redirect_en) fetch_pc_d = redir_tgt;
                if (!err_d && (redirect_en || (cnt_pop < CW'(DEPTH)))) state_d = IF_ST_REQ;
            end
            IF_ST_REQ: begin
                if (imem_ack) begin
                    if (redirect_en) begin
                        fetch_pc_d = redir_tgt;
                        state_d    = err_d ? IF_ST_IDLE : IF_ST_REQ;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + W'(INST_BYTES);
                        state_d    = ((cnt_pop + CW'(1)) < CW'(DEPTH)) ? IF_ST_REQ : IF_ST_IDLE;
                    end
                end else if (redirect_en) begin
                    targ_d  = redir_tgt;
                    state_d = IF_ST_FLUSH;
                end
            end
            IF_ST_FLUSH: begin
                if (redirect_en) targ_d = redir_tgt;
                if (imem_ack) begin
                    fetch_pc_d = redirect_en ? redir_tgt : targ_q;
                    state_d    = err_d ? IF_ST_IDLE : IF_ST_REQ;
                end
            end
            default: state_d = IF_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IF_ST_IDLE;
            fetch_pc_q <= RESET_PC;
            targ_q     <= RESET_PC;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            targ_q     <= targ_d;
            err_q      <= err_d;
        end
    end

    ifetch_queue #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_en),
        .push_inst  (imem_rdata),
        .push_pc    (fetch_pc_q),
        .head_valid (inst_valid),
        .head_inst  (inst),
        .head_pc    (inst_pc),
        .count      (q_count)
    );

    assign imem_req  = (state_q != IF_ST_IDLE);
    assign imem_addr = fetch_pc_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: accepted fetch words go into a scoreboard and are
// compared in order as the decode side pops them.
`timescale 1ns/1ps
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, inst_valid, fetch_err;
    logic [31:0] imem_addr, inst, inst_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    sb_t         sb [$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] pend = '0;
    logic        flushing = 1'b0;
    logic        s_req, s_valid, s_err;
    logic [31:0] s_addr, s_pc;

    always #5 clk = ~clk;

    ifetch_unit #(
        .W        (32),
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .fetch_err   (fetch_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic ack, input logic redir, input logic [31:0] rpc, input logic stl);
        logic [31:0] t;
        logic        acc;
        sb_t         e;
        s_req       = imem_req;
        s_valid     = inst_valid;
        s_err       = fetch_err;
        s_addr      = imem_addr;
        s_pc        = inst_pc;
        acc         = ack && s_req;
        stall       = stl;
        redirect_en = redir;
        redirect_pc = rpc;
        imem_ack    = acc;
        imem_rdata  = acc ? mem_word(imem_addr) : '0;
        #1;
        if (s_req) chk("imem_addr", imem_addr, exp_addr);
        if (s_valid && !stl) begin
            if (sb.size() == 0) begin
                chk("unexpected_inst", {31'b0, s_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("inst_pc", inst_pc, e.pc);
                chk("inst", inst, e.inst);
            end
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        t = rpc;
`else
        t = {rpc[31:2], 2'b00};
`endif
        if (redir) sb.delete();
        if (acc) begin
            if (redir) begin
                exp_addr = t;
                flushing = 1'b0;
            end else if (flushing) begin
                exp_addr = pend;
                flushing = 1'b0;
            end else begin
                e.pc   = exp_addr;
                e.inst = imem_rdata;
                sb.push_back(e);
                exp_addr = exp_addr + 32'd4;
            end
        end else if (redir) begin
            if (s_req) begin
                pend     = t;
                flushing = 1'b1;
            end else begin
                exp_addr = t;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        imem_ack    = 1'b0;
        redirect_en = 1'b0;
        stall       = 1'b0;
        redirect_pc = '0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        sb.delete();
        exp_addr = 32'h0;
        flushing = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input string tag);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        // 1: ack every cycle, no stall
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            chk("t1_req", {31'b0, s_req}, {31'b0, (i >= 1)});
            chk("t1_valid", {31'b0, s_valid}, {31'b0, (i >= 2)});
        end
        drain("t1_drain");

        // 2: stall held fills the queue, then resumes at 8
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            chk("t2_req", {31'b0, s_req}, {31'b0, (i == 1 || i == 2)});
        end
        chk("t2_accepted", 32'(sb.size()), 32'd2);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            if (i == 1) begin
                chk("t2_resume_req", {31'b0, s_req}, 32'd1);
                chk("t2_resume_addr", s_addr, 32'h8);
            end
        end
        drain("t2_drain");

        // 3: delayed ack with redirect mid-request
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_hold_addr", s_addr, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_new_req", {31'b0, s_req}, 32'd1);
        chk("t3_new_addr", s_addr, 32'h100);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t3_first_valid", {31'b0, s_valid}, 32'd1);
        chk("t3_first_pc", s_pc, 32'h100);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        drain("t3_drain");

        // 4: redirect together with ack
        do_reset();
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h40, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t4_valid_cleared", {31'b0, s_valid}, 32'd0);
        chk("t4_req", {31'b0, s_req}, 32'd1);
        chk("t4_addr", s_addr, 32'h40);
        repeat (4) step(1'b1, 1'b0, 32'h0, 1'b0);
        drain("t4_drain");

        // 5: misaligned redirect target
        do_reset();
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h102, 1'b0);
`ifdef IFETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            chk("t5_err", {31'b0, s_err}, 32'd1);
            chk("t5_no_req", {31'b0, s_req}, 32'd0);
            chk("t5_no_valid", {31'b0, s_valid}, 32'd0);
        end
`else
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_req", {31'b0, s_req}, 32'd1);
        chk("t5_addr", s_addr, 32'h100);
        chk("t5_err", {31'b0, s_err}, 32'd0);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_err_late", {31'b0, fetch_err}, 32'd0);
        drain("t5_drain");
`endif

        // 6: reset asserted while in FLUSH
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_in_flush_req", {31'b0, imem_req}, 32'd1);
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_idle", {31'b0, s_req}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_req", {31'b0, s_req}, 32'd1);
        chk("t6_addr", s_addr, 32'h0);
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
